pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DW  32  payload width in bits, legal range 1..256
  CLEAR_ON_FLUSH  1  1 = zero payload registers on flush; 0 = keep stale payload
  CNT_W  16  width of the back-pressure cycle counter, legal range 4..32
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state updates on its rising edge
  rst  in  1  asynchronous, active-low reset
  flush  in  1  synchronous discard of all held entries
  in_valid  in  1  upstream offers in_data
  in_ready  out  1  stage can accept a word this cycle
  in_data  in  DW  upstream payload
  out_valid  out  1  out_data holds a valid word
  out_ready  in  1  downstream accepts out_data this cycle
  out_data  out  DW  payload presented downstream
  occupancy  out  2  number of held entries: 0, 1 or 2
  bp_cycles  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Function
REQ-003 Accept event SHALL be in_valid & in_ready; issue event SHALL be out_valid & out_ready.
REQ-004 Storage SHALL be two DW-bit registers: main, which drives out_data, and skid.
REQ-005 State SHALL be one of EMPTY (occupancy 0), ONE (1) or FULL (2); occupancy SHALL be driven directly from the state register.
REQ-006 in_ready SHALL be 1 exactly when the state is not FULL, decoded from registers only, with no combinational path from out_ready.
REQ-007 out_valid SHALL be 1 exactly when the state is not EMPTY; out_data SHALL always equal main.
REQ-008 EMPTY, accept: main <= in_data, next state ONE.
REQ-009 ONE, accept and issue together: main <= in_data, state stays ONE (one word per cycle throughput).
REQ-010 ONE, accept only: skid <= in_data, next state FULL.
REQ-011 ONE, issue only: next state EMPTY.
REQ-012 FULL, issue: main <= skid, next state ONE; in_valid is ignored in FULL because in_ready is 0.
REQ-013 In every state, no accept and no issue SHALL leave the state and both registers unchanged.
REQ-014 Input-to-output latency SHALL be 1 cycle: a word accepted at edge N is visible on out_data after edge N.
REQ-015 Ordering SHALL be strict FIFO: no word is dropped or duplicated except by flush or reset.
REQ-016 flush SHALL override every other event in the same cycle:
  - next state is EMPTY;
  - an in_data offered that cycle is discarded;
  - an issue handshake that cycle still counts as consumed downstream;
  - if CLEAR_ON_FLUSH=1, main and skid become 0; otherwise they hold their values.
REQ-017 bp_cycles SHALL increment by 1 on each edge where out_valid=1 and out_ready=0, and SHALL saturate at all-ones.
REQ-018 flush SHALL NOT clear bp_cycles.

Reset
REQ-019 When rst=0, asynchronously and regardless of clk:
  - state is EMPTY (occupancy=0, out_valid=0, in_ready=1);
  - main, skid and bp_cycles are 0.
REQ-020 Deassertion of rst SHALL take effect at the first rising clk edge after rst=1; an accept on that edge SHALL be honoured.
REQ-021 Asserting rst mid-operation SHALL discard held words immediately, with no partial or corrupted output cycle.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
  - Streaming: out_ready=1, in_valid=1, data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, occupancy stays 1, bp_cycles=0.
  - Skid fill: load 0xA, hold out_ready=0, offer 0xB then 0xC -> occupancy 2, in_ready=0, 0xC not accepted; release out_ready -> outputs 0xA then 0xB, then 0xC is accepted.
  - Flush in FULL with CLEAR_ON_FLUSH=1 and in_valid=1 (data 0x55) -> next cycle occupancy 0, out_data=0, 0x55 never appears at the output; repeat with CLEAR_ON_FLUSH=0 -> out_data keeps its old value, out_valid=0.
  - Counter saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> bp_cycles=15 and holds there; a flush leaves it at 15.
  - Async reset: assert rst=0 between clock edges while in FULL -> occupancy 0 and out_valid 0 before the next edge; a word offered on the first edge after release is output unchanged.
  - Random stimulus: in_valid and out_ready each random at 50% for 10k cycles, DW=8 -> scoreboard shows FIFO order intact and in_ready never 1 while occupancy=2.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer that gives full throughput while keeping in_ready off the out_ready path.
module pipe_skid_stage #(
  parameter int DW             = 32,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bp_cycles
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t           state_q, state_d;
  logic [DW-1:0]    main_q, main_d, skid_q, skid_d;
  logic [CNT_W-1:0] bp_q, bp_d;
  logic             acc, iss;
  assign in_ready  = state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign bp_cycles = bp_q;
  assign acc       = in_valid & in_ready;
  assign iss       = out_valid & out_ready;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    bp_d    = (out_valid & ~out_ready & ~&bp_q) ? bp_q + 1'b1 : bp_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = CLEAR_ON_FLUSH ? '0 : main_q;
      skid_d  = CLEAR_ON_FLUSH ? '0 : skid_q;
    end else begin
      case (state_q)
        EMPTY: if (acc) begin
          main_d  = in_data;
          state_d = ONE;
        end
        ONE: begin
          main_d  = (acc & iss) ? in_data : main_q;
          skid_d  = (acc & ~iss) ? in_data : skid_q;
          state_d = (acc & ~iss) ? FULL : (iss & ~acc) ? EMPTY : ONE;
        end
        FULL: if (iss) begin
          main_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      bp_q    <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      bp_q    <= bp_d;
    end
  end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and random checks on two instances differing only in CLEAR_ON_FLUSH.
module tb_pipe_skid_stage;
  logic       clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [7:0] out_data_a, out_data_b;
  logic [1:0] occ_a, occ_b;
  logic [3:0] bp_a, bp_b;
  int         errs = 0, checks = 0;
  logic [7:0] q[$];

  pipe_skid_stage #(.DW(8), .CLEAR_ON_FLUSH(1'b1), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .occupancy(occ_a), .bp_cycles(bp_a));
  pipe_skid_stage #(.DW(8), .CLEAR_ON_FLUSH(1'b0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .occupancy(occ_b), .bp_cycles(bp_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_occ", occ_a, 0);
    chk("rst_valid", out_valid_a, 0);
    chk("rst_ready", in_ready_a, 1);
    chk("rst_data", out_data_a, 0);
    chk("rst_bp", bp_a, 0);
    rst = 1'b1;
    // streaming: each word appears one edge after it is offered
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i);
      step();
      chk("stream_data", out_data_a, i);
      chk("stream_occ", occ_a, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain", occ_a, 0);
    chk("stream_bp", bp_a, 0);
    // skid fill
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h0A;
    step();
    chk("skid_a", out_data_a, 8'h0A);
    in_data = 8'h0B;
    step();
    chk("skid_full", occ_a, 2);
    chk("skid_rdy", in_ready_a, 0);
    in_data = 8'h0C;
    step();
    chk("skid_hold_occ", occ_a, 2);
    chk("skid_hold_data", out_data_a, 8'h0A);
    chk("skid_bp", bp_a, 2);
    out_ready = 1'b1;
    step();
    chk("skid_b", out_data_a, 8'h0B);
    chk("skid_b_occ", occ_a, 1);
    step();
    chk("skid_c", out_data_a, 8'h0C);
    chk("skid_c_occ", occ_a, 1);
    in_valid = 1'b0;
    step();
    chk("skid_empty", occ_a, 0);
    // flush in FULL with a word on the input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    step();
    in_data = 8'h22;
    step();
    chk("fl_full", occ_a, 2);
    chk("fl_bp_pre", bp_a, 3);
    flush   = 1'b1;
    in_data = 8'h55;
    step();
    chk("fl_occ", occ_a, 0);
    chk("fl_valid", out_valid_a, 0);
    chk("fl_clr_data", out_data_a, 0);
    chk("fl_keep_data", out_data_b, 8'h11);
    chk("fl_keep_valid", out_valid_b, 0);
    chk("fl_bp", bp_a, 4);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("fl_no55", out_data_a, 0);
    chk("fl_idle_occ", occ_a, 0);
    // counter saturation
    in_valid = 1'b1;
    in_data  = 8'h33;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("sat_mid", bp_a, 14);
    for (int i = 0; i < 10; i++) step();
    chk("sat_top", bp_a, 15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("sat_flush", bp_a, 15);
    chk("sat_flush_occ", occ_a, 0);
    // async reset while FULL, then an accept on the first edge after release
    in_valid = 1'b1;
    in_data  = 8'h44;
    step();
    in_data = 8'h66;
    step();
    chk("ar_full", occ_a, 2);
    #2 rst = 1'b0;
    #1;
    chk("ar_occ", occ_a, 0);
    chk("ar_valid", out_valid_a, 0);
    chk("ar_ready", in_ready_a, 1);
    chk("ar_data", out_data_a, 0);
    chk("ar_bp", bp_a, 0);
    @(negedge clk);
    rst       = 1'b1;
    in_data   = 8'h77;
    out_ready = 1'b1;
    step();
    chk("ar_first", out_data_a, 8'h77);
    chk("ar_first_occ", occ_a, 1);
    in_valid = 1'b0;
    step();
    chk("ar_drain", occ_a, 0);
    // random traffic against a queue model
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      #1;
      chk("rnd_occ", occ_a, q.size());
      chk("rnd_valid", out_valid_a, q.size() != 0);
      if (occ_a == 2'd2) chk("rnd_rdy_full", in_ready_a, 0);
      if (q.size() != 0 && out_ready) begin
        chk("rnd_data", out_data_a, q[0]);
        void'(q.pop_front());
      end
      if (in_valid && q.size() < 2 + ((out_ready && out_valid_a) ? 1 : 0) && occ_a != 2'd2) q.push_back(in_data);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
